// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl
//   Generates the clock enable that paces every CPU state element. The CPU
//   either free-runs (optionally slowed by an enable divider) or advances one
//   cycle per rising edge of a step request. The block counts the enables it
//   issues and, when built with CYCLE_LIMIT_EN, halts after a programmed
//   number of them.
//
// Parameters
//   CNT_W   width of the cycle counter and of the cycle limit
//   DIV_W   width of the enable divider
//
// Optional feature
//   CYCLE_LIMIT_EN  when defined, adds the limit input and the HALT path.
//                   When undefined, HALT is never entered and halted stays 0.
//
// Ports
//   clock    sole clock, everything updates on its rising edge
//   reset    synchronous active-high reset, overrides run/step/clear
//   run      level request for free-running execution
//   step     single-step request, acted on at its rising edge in IDLE
//   clear    leaves HALT and zeroes the cycle count (any state)
//   div      in RUN, cpu_en asserts once every div+1 clocks
//   limit    cycle limit, 0 disables halting (CYCLE_LIMIT_EN only)
//   cpu_en   clock enable for CPU state elements
//   cycles   number of cpu_en pulses issued, saturating at all-ones
//   state    IDLE=0, RUN=1, STEP=2, HALT=3
//   halted   high exactly when state is HALT

module cpu_clock_ctrl #(
  parameter int CNT_W = 32,
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
`ifdef CYCLE_LIMIT_EN
  input  logic [CNT_W-1:0] limit,
`endif
  output logic             cpu_en,
  output logic [CNT_W-1:0] cycles,
  output logic [1:0]       state,
  output logic             halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             step_q;
  logic             stepRise;
  logic             limitHit;

  assign stepRise = step & ~step_q;

  // The divider uses >= so that lowering div while running releases the
  // enable immediately instead of waiting for the counter to wrap around.
  assign cpu_en = ((state_q == RUN) && (divCnt_q >= div)) || (state_q == STEP);

`ifdef CYCLE_LIMIT_EN
  // A hit is the enable that will bring the count up to the limit; the state
  // machine then parks in HALT no matter what run says.
  assign limitHit = cpu_en && (limit != '0) && ((cycles_q + CNT_W'(1)) == limit);
`else
  assign limitHit = 1'b0;
`endif

  // Next-state logic. run beats a simultaneous step edge in IDLE, and step
  // edges seen in any other state are dropped rather than remembered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (run)           state_d = RUN;
        else if (stepRise) state_d = STEP;
      end
      RUN: begin
        if (limitHit)      state_d = HALT;
        else if (!run)     state_d = IDLE;
      end
      STEP:                state_d = limitHit ? HALT : IDLE;
      HALT: begin
        if (clear)         state_d = IDLE;
      end
      default:             state_d = IDLE;
    endcase
  end

  // Divider and cycle counter next values. The divider sits at zero outside
  // RUN so every entry into RUN starts a fresh interval; clear beats a
  // coincident enable and the count never wraps.
  always_comb begin
    divCnt_d = '0;
    if ((state_q == RUN) && !cpu_en) divCnt_d = divCnt_q + DIV_W'(1);

    cycles_d = cycles_q;
    if (clear)                              cycles_d = '0;
    else if (cpu_en && (cycles_q != '1))    cycles_d = cycles_q + CNT_W'(1);
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      divCnt_q <= '0;
      cycles_q <= '0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      divCnt_q <= divCnt_d;
      cycles_q <= cycles_d;
      step_q   <= step;
    end
  end

  assign cycles = cycles_q;
  assign state  = state_q;
  assign halted = (state_q == HALT);

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl
//   Directed-vector bench for cpu_clock_ctrl. Each scenario task drives its
//   own stimulus and compares outputs against hand-derived values. Inputs
//   change and outputs are observed 1 time unit after each rising edge.

module tb_cpu_clock_ctrl;

  logic        clock;
  logic        reset;
  logic        run;
  logic        step;
  logic        clear;
  logic [7:0]  div;
`ifdef CYCLE_LIMIT_EN
  logic [31:0] limit;
`endif
  logic        cpu_en;
  logic [31:0] cycles;
  logic [1:0]  state;
  logic        halted;

  int vectors;
  int miscompares;

  cpu_clock_ctrl #(.CNT_W(32), .DIV_W(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .run    (run),
    .step   (step),
    .clear  (clear),
    .div    (div),
`ifdef CYCLE_LIMIT_EN
    .limit  (limit),
`endif
    .cpu_en (cpu_en),
    .cycles (cycles),
    .state  (state),
    .halted (halted)
  );

  // 10-unit clock period
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle just past it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Return every input to idle and hold reset for two edges
  task automatic doReset();
    reset = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    clear = 1'b0;
    div   = 8'd0;
`ifdef CYCLE_LIMIT_EN
    limit = 32'd0;
`endif
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    vectors++;
    if (state !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %0d expected 0", state);
    end
    vectors++;
    if (cycles !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_cycles: got %0d expected 0", cycles);
    end
    vectors++;
    if (cpu_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_cpu_en: got %b expected 0", cpu_en);
    end
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_halted: got %b expected 0", halted);
    end
  endtask

  // div=0, run high for 5 sampled edges: 5 enables starting one clock later
  task automatic test_run_div0();
    int pulses;
    int runStates;
    doReset();
    div = 8'd0;
    run = 1'b1;
    vectors++;
    if (cpu_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL div0_no_early_en: got %b expected 0", cpu_en);
    end
    pulses = 0;
    runStates = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cpu_en === 1'b1) pulses++;
      if (state === 2'd1) runStates++;
    end
    run = 1'b0;
    tick();
    vectors++;
    if (pulses != 5) begin
      miscompares++;
      $display("[TB] FAIL div0_pulses: got %0d expected 5", pulses);
    end
    vectors++;
    if (runStates != 5) begin
      miscompares++;
      $display("[TB] FAIL div0_run_states: got %0d expected 5", runStates);
    end
    vectors++;
    if (cycles !== 32'd5) begin
      miscompares++;
      $display("[TB] FAIL div0_cycles: got %0d expected 5", cycles);
    end
    vectors++;
    if (state !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL div0_end_state: got %0d expected 0", state);
    end
    vectors++;
    if (cpu_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL div0_end_cpu_en: got %b expected 0", cpu_en);
    end
  endtask

  // div=3: enable on every 4th RUN clock, 3 counted after 12 RUN clocks
  task automatic test_div3();
    logic expEn;
    doReset();
    div = 8'd3;
    run = 1'b1;
    tick();
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) tick();
      expEn = ((k % 4) == 3);
      vectors++;
      if (cpu_en !== expEn) begin
        miscompares++;
        $display("[TB] FAIL div3_en_k%0d: got %b expected %b", k, cpu_en, expEn);
      end
    end
    vectors++;
    if (cycles !== 32'd3) begin
      miscompares++;
      $display("[TB] FAIL div3_cycles: got %0d expected 3", cycles);
    end
    run = 1'b0;
    tick();
  endtask

  // Lowering div below the running count releases the enable at once
  task automatic test_div_lower();
    doReset();
    div = 8'd5;
    run = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (cpu_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL divlow_before: got %b expected 0", cpu_en);
    end
    div = 8'd1;
    #1;
    vectors++;
    if (cpu_en !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL divlow_release: got %b expected 1", cpu_en);
    end
    tick();
    vectors++;
    if (cpu_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL divlow_restart: got %b expected 0", cpu_en);
    end
    tick();
    vectors++;
    if (cpu_en !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL divlow_period2: got %b expected 1", cpu_en);
    end
    run = 1'b0;
    tick();
  endtask

  // Three short step pulses then step held 10 clocks: 4 single-clock enables
  task automatic test_step();
    int pulses;
    int stepStates;
    doReset();
    pulses = 0;
    stepStates = 0;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      tick();
      if (cpu_en === 1'b1) pulses++;
      if (state === 2'd2) stepStates++;
      step = 1'b0;
      tick();
      if (cpu_en === 1'b1) pulses++;
      tick();
      if (cpu_en === 1'b1) pulses++;
    end
    step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_en === 1'b1) pulses++;
      if (state === 2'd2) stepStates++;
    end
    step = 1'b0;
    tick();
    tick();
    vectors++;
    if (pulses != 4) begin
      miscompares++;
      $display("[TB] FAIL step_pulses: got %0d expected 4", pulses);
    end
    vectors++;
    if (stepStates != 4) begin
      miscompares++;
      $display("[TB] FAIL step_states: got %0d expected 4", stepStates);
    end
    vectors++;
    if (cycles !== 32'd4) begin
      miscompares++;
      $display("[TB] FAIL step_cycles: got %0d expected 4", cycles);
    end
  endtask

  // A step edge during RUN is dropped, not replayed on return to IDLE
  task automatic test_step_ignored();
    doReset();
    run = 1'b1;
    tick();
    step = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    vectors++;
    if (state !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL step_not_queued: got state %0d expected 0", state);
    end
    step = 1'b0;
    tick();
  endtask

  // run and step rising together: RUN wins and STEP is never visited
  task automatic test_run_step_same();
    int stepSeen;
    doReset();
    stepSeen = 0;
    run  = 1'b1;
    step = 1'b1;
    tick();
    vectors++;
    if (state !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL runstep_state: got %0d expected 1", state);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (state === 2'd2) stepSeen++;
    end
    run  = 1'b0;
    step = 1'b0;
    tick();
    if (state === 2'd2) stepSeen++;
    tick();
    if (state === 2'd2) stepSeen++;
    vectors++;
    if (stepSeen != 0) begin
      miscompares++;
      $display("[TB] FAIL runstep_no_step: got %0d step clocks expected 0", stepSeen);
    end
  endtask

  // clear coinciding with an enable zeroes the count and leaves RUN alone
  task automatic test_clear();
    doReset();
    run = 1'b1;
    tick();
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++;
    if (cycles !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL clear_wins: got %0d expected 0", cycles);
    end
    vectors++;
    if (state !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL clear_keeps_run: got %0d expected 1", state);
    end
    tick();
    vectors++;
    if (cycles !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL clear_recount: got %0d expected 1", cycles);
    end
    run = 1'b0;
    tick();
  endtask

`ifdef CYCLE_LIMIT_EN
  // limit=7: exactly 7 enables then HALT until clear
  task automatic test_limit();
    int pulses;
    doReset();
    limit = 32'd7;
    run   = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cpu_en === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 7) begin
      miscompares++;
      $display("[TB] FAIL limit_pulses: got %0d expected 7", pulses);
    end
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL limit_halted: got %b expected 1", halted);
    end
    vectors++;
    if (cycles !== 32'd7) begin
      miscompares++;
      $display("[TB] FAIL limit_cycles: got %0d expected 7", cycles);
    end
    run   = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++;
    if (state !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL limit_clear_state: got %0d expected 0", state);
    end
    vectors++;
    if (cycles !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL limit_clear_cycles: got %0d expected 0", cycles);
    end
  endtask
`endif

  // Reset mid-RUN with cycles=20 returns everything to idle in one edge
  task automatic test_reset_mid_run();
    doReset();
    run = 1'b1;
    for (int i = 0; i < 21; i++) tick();
    vectors++;
    if (cycles !== 32'd20) begin
      miscompares++;
      $display("[TB] FAIL midrun_cycles: got %0d expected 20", cycles);
    end
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrun_not_halted: got %b expected 0", halted);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (state !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL midrun_reset_state: got %0d expected 0", state);
    end
    vectors++;
    if (cycles !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL midrun_reset_cycles: got %0d expected 0", cycles);
    end
    vectors++;
    if (cpu_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrun_reset_cpu_en: got %b expected 0", cpu_en);
    end
    reset = 1'b0;
    run   = 1'b0;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_run_div0();
    test_div3();
    test_div_lower();
    test_step();
    test_step_ignored();
    test_run_step_same();
    test_clear();
`ifdef CYCLE_LIMIT_EN
    test_limit();
`endif
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
